dino_jump_fsm: RTL and testbench
================================

// Module: dino_jump_fsm
// PURPOSE
//  Player-motion stage. Sits directly downstream of the per-button debouncers.
//  Turns the debounced up/down levels into game state, a 6-bit vertical position and status flags.
//  Jump physics (fixed launch velocity, constant gravity) advance once per game_tick.
//  Outputs feed the renderer and the collision/score logic.
// PARAMETERS
//  POS_W     6  width of player_position (unsigned height above ground)
//  VEL_W     5  width of signed vertical velocity register
//  JUMP_VEL  7  launch velocity loaded on a jump, units of position per tick
//  GRAVITY   1  amount subtracted from velocity after every airborne tick
// PORTS
//  clk              in   1      system clock, all logic on rising edge
//  reset_n          in   1      asynchronous active-low reset
//  game_tick        in   1      one-clk strobe; physics advance only on this strobe
//  button_up        in   1      debounced jump / start level
//  button_down      in   1      debounced duck level
//  crash            in   1      collision level from obstacle logic
//  player_position  out  POS_W  height above ground, 0 = on ground
//  jumping          out  1      high while in JUMP
//  ducking          out  1      high while in DUCK
//  game_start_pulse out  1      one-clk pulse on entry to RUN from IDLE or DEAD
//  jump_pulse       out  1      one-clk pulse on entry to JUMP
//  game_over_pulse  out  1      one-clk pulse on entry to DEAD
// BEHAVIOUR
//  Registers and outputs
//  - All outputs are registered.
//  - Reset state: IDLE; player_position=0; vel=0; all flags and pulses 0.
//  - up_q (the previous button_up sample) resets to 1, so a button held through reset is not an edge.
//  - up_edge = button_up & ~up_q. up_q updates every clk.
//  - A condition sampled at edge N produces its state change and output at edge N, visible from N on.
//  - Each pulse is high for exactly one clk.
//  States: IDLE, RUN, DUCK, JUMP, DEAD
//  - IDLE: on up_edge go to RUN and fire game_start_pulse. No other input has any effect.
//  - RUN, DUCK and JUMP share one rule: crash=1 has top priority.
//    -> go to DEAD and fire game_over_pulse.
//    -> player_position freezes; vel is cleared.
//    -> That cycle's game_tick is ignored.
//  - RUN:
//    - up_edge -> JUMP; vel=JUMP_VEL; fire jump_pulse. This takes priority over button_down.
//    - Otherwise button_down=1 -> DUCK.
//  - DUCK: ducking=1.
//    - up_edge -> JUMP, same as from RUN.
//    - Otherwise button_down=0 -> RUN.
//  - JUMP: jumping=1.
//    - On game_tick, next = pos + vel, computed signed at POS_W+2 bits.
//    - If next <= 0: pos=0, vel=0. Exit to DUCK if button_down=1, else to RUN.
//    - If next > 2^POS_W-1: clamp pos to 2^POS_W-1.
//    - Otherwise pos = next.
//    - When airborne, vel -= GRAVITY, saturating at -2^(VEL_W-1).
//    - button_up and button_down are ignored while airborne: no double jump, no fast-fall.
//  - Entry cycle: the launch edge into JUMP never moves the position, even if game_tick is high that cycle.
//    The first rise happens on the next tick.
//  - DEAD: outputs hold; flags are 0.
//    - up_edge with crash=0 -> RUN; pos=0; vel=0; fire game_start_pulse.
//    - up_edge with crash=1 is ignored.
//  - Asynchronous reset mid-jump returns to IDLE with pos=0 immediately. No pulses are emitted.
// TESTING
//  1. Reset with button_up held high, then hold 20 clk
//     -> stays IDLE, no pulses.
//     Release, then press -> game_start_pulse for 1 clk, state RUN.
//  2. RUN; up_edge; then 15 ticks spaced 4 clk apart
//     -> jump_pulse once.
//     -> pos after each tick: 7,13,18,22,25,27,28,28,27,25,22,18,13,7,0.
//     -> jumping drops on tick 15, state RUN.
//  3. In RUN hold button_down
//     -> ducking=1 next clk.
//     Assert up_edge while still ducking -> JUMP, ducking=0, jumping=1.
//     Keep down held until landing -> lands in DUCK.
//  4. Mid-jump at pos=22, assert crash and game_tick in the same clk
//     -> DEAD, pos stays 22, game_over_pulse once.
//     up_edge while crash=1 -> ignored.
//     Drop crash, then up_edge -> RUN, pos=0, game_start_pulse.
//  5. Press button_up again during JUMP
//     -> no jump_pulse, trajectory unchanged.
//     Rerun with JUMP_VEL=15 -> pos clamps at 63, no wrap.
//  6. Deassert reset_n asynchronously mid-jump between clk edges
//     -> all outputs 0 immediately; IDLE after release.

Source files
------------

// File: rtl/dino_jump_fsm.sv
// Player-motion stage: turns debounced up/down/crash levels into game state,
// a vertical position with fixed-launch / constant-gravity jump physics, and status pulses.
module dino_jump_fsm #(
    parameter int POS_W    = 6,
    parameter int VEL_W    = 5,
    parameter int JUMP_VEL = 7,
    parameter int GRAVITY  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             game_tick,
    input  logic             button_up,
    input  logic             button_down,
    input  logic             crash,
    output logic [POS_W-1:0] player_position,
    output logic             jumping,
    output logic             ducking,
    output logic             game_start_pulse,
    output logic             jump_pulse,
    output logic             game_over_pulse
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_DUCK = 3'd2,
        ST_JUMP = 3'd3,
        ST_DEAD = 3'd4
    } state_t;

    localparam logic signed [VEL_W-1:0] JUMP_V    = VEL_W'(JUMP_VEL);
    localparam logic signed [VEL_W:0]   GRAV_W    = (VEL_W+1)'(GRAVITY);
    localparam logic signed [VEL_W:0]   VEL_MIN_W = {2'b11, {(VEL_W-1){1'b0}}};
    localparam logic signed [VEL_W-1:0] VEL_MIN   = {1'b1, {(VEL_W-1){1'b0}}};
    localparam logic signed [POS_W+1:0] POS_MAX_S = {2'b00, {POS_W{1'b1}}};
    localparam logic signed [POS_W+1:0] ZERO_S    = '0;

    state_t                   state_r;
    logic                     up_q_r;
    logic signed [VEL_W-1:0]  vel_r;
    logic                     up_edge_s;
    logic signed [POS_W+1:0]  next_pos_s;
    logic signed [VEL_W:0]    vel_dec_s;
    logic signed [VEL_W-1:0]  next_vel_s;

    // Edge detect and one-tick physics step (position widened so overshoot and landing are visible).
    always_comb begin
        up_edge_s  = button_up & ~up_q_r;
        next_pos_s = $signed({2'b00, player_position})
                   + $signed({{(POS_W+2-VEL_W){vel_r[VEL_W-1]}}, vel_r});
        vel_dec_s  = $signed({vel_r[VEL_W-1], vel_r}) - GRAV_W;
        if (vel_dec_s < VEL_MIN_W) begin
            next_vel_s = VEL_MIN;
        end else begin
            next_vel_s = vel_dec_s[VEL_W-1:0];
        end
    end

    // Game state machine with registered flags, position and one-clock pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r          <= ST_IDLE;
            up_q_r           <= 1'b1;
            vel_r            <= '0;
            player_position  <= '0;
            jumping          <= 1'b0;
            ducking          <= 1'b0;
            game_start_pulse <= 1'b0;
            jump_pulse       <= 1'b0;
            game_over_pulse  <= 1'b0;
        end else begin
            up_q_r           <= button_up;
            game_start_pulse <= 1'b0;
            jump_pulse       <= 1'b0;
            game_over_pulse  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (up_edge_s) begin
                        state_r          <= ST_RUN;
                        game_start_pulse <= 1'b1;
                    end
                end
                ST_RUN, ST_DUCK: begin
                    if (crash) begin
                        state_r         <= ST_DEAD;
                        game_over_pulse <= 1'b1;
                        vel_r           <= '0;
                        ducking         <= 1'b0;
                    end else if (up_edge_s) begin
                        state_r    <= ST_JUMP;
                        vel_r      <= JUMP_V;
                        jump_pulse <= 1'b1;
                        jumping    <= 1'b1;
                        ducking    <= 1'b0;
                    end else if (button_down) begin
                        state_r <= ST_DUCK;
                        ducking <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                        ducking <= 1'b0;
                    end
                end
                ST_JUMP: begin
                    if (crash) begin
                        state_r         <= ST_DEAD;
                        game_over_pulse <= 1'b1;
                        vel_r           <= '0;
                        jumping         <= 1'b0;
                    end else if (game_tick) begin
                        if (next_pos_s <= ZERO_S) begin
                            player_position <= '0;
                            vel_r           <= '0;
                            jumping         <= 1'b0;
                            ducking         <= button_down;
                            state_r         <= button_down ? ST_DUCK : ST_RUN;
                        end else if (next_pos_s > POS_MAX_S) begin
                            player_position <= {POS_W{1'b1}};
                            vel_r           <= next_vel_s;
                        end else begin
                            player_position <= next_pos_s[POS_W-1:0];
                            vel_r           <= next_vel_s;
                        end
                    end
                end
                ST_DEAD: begin
                    // A restart press is only honoured once the collision has cleared.
                    if (up_edge_s && !crash) begin
                        state_r          <= ST_RUN;
                        player_position  <= '0;
                        vel_r            <= '0;
                        game_start_pulse <= 1'b1;
                    end
                end
                default: begin
                    state_r         <= ST_IDLE;
                    player_position <= '0;
                    vel_r           <= '0;
                    jumping         <= 1'b0;
                    ducking         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dino_jump_fsm.sv
// Directed bench for dino_jump_fsm: two instances (launch velocity 7 and 15) share stimulus
// and are checked every clock against an integer game model plus hand-computed literals.
module tb_dino_jump_fsm;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic game_tick = 1'b0, button_up = 1'b1, button_down = 1'b0, crash = 1'b0;
    logic [5:0] pos_a [2];
    logic jmp_a [2], duck_a [2], start_a [2], jp_a [2], over_a [2];

    always #5 clk = ~clk;

    dino_jump_fsm #(.JUMP_VEL(7)) dut0 (
        .clk(clk), .reset_n(reset_n), .game_tick(game_tick), .button_up(button_up),
        .button_down(button_down), .crash(crash), .player_position(pos_a[0]),
        .jumping(jmp_a[0]), .ducking(duck_a[0]), .game_start_pulse(start_a[0]),
        .jump_pulse(jp_a[0]), .game_over_pulse(over_a[0]));

    dino_jump_fsm #(.JUMP_VEL(15)) dut1 (
        .clk(clk), .reset_n(reset_n), .game_tick(game_tick), .button_up(button_up),
        .button_down(button_down), .crash(crash), .player_position(pos_a[1]),
        .jumping(jmp_a[1]), .ducking(duck_a[1]), .game_start_pulse(start_a[1]),
        .jump_pulse(jp_a[1]), .game_over_pulse(over_a[1]));

    localparam int M_IDLE = 0, M_GROUND = 1, M_AIR = 2, M_DEAD = 3;
    int m_mode [2], m_h [2], m_v [2], m_duck [2], m_start [2], m_jp [2], m_over [2];
    int m_upq;
    int n_chk = 0, n_pass = 0, jp_count0 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_upq = 1;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_IDLE; m_h[i] = 0; m_v[i] = 0; m_duck[i] = 0;
            m_start[i] = 0; m_jp[i] = 0; m_over[i] = 0;
        end
    endtask

    // One clock of game rules for both players, using plain integer physics.
    task automatic model_step();
        int edge_up, n, jv;
        edge_up = (button_up && m_upq == 0) ? 1 : 0;
        m_upq = button_up ? 1 : 0;
        for (int i = 0; i < 2; i++) begin
            jv = (i == 0) ? 7 : 15;
            m_start[i] = 0; m_jp[i] = 0; m_over[i] = 0;
            if (m_mode[i] == M_IDLE) begin
                if (edge_up == 1) begin m_mode[i] = M_GROUND; m_start[i] = 1; end
            end else if (m_mode[i] == M_GROUND) begin
                if (crash) begin m_mode[i] = M_DEAD; m_over[i] = 1; m_duck[i] = 0; m_v[i] = 0; end
                else if (edge_up == 1) begin m_mode[i] = M_AIR; m_v[i] = jv; m_jp[i] = 1; m_duck[i] = 0; end
                else m_duck[i] = button_down ? 1 : 0;
            end else if (m_mode[i] == M_AIR) begin
                if (crash) begin m_mode[i] = M_DEAD; m_over[i] = 1; m_v[i] = 0; end
                else if (game_tick) begin
                    n = m_h[i] + m_v[i];
                    if (n <= 0) begin
                        m_h[i] = 0; m_v[i] = 0; m_mode[i] = M_GROUND;
                        m_duck[i] = button_down ? 1 : 0;
                    end else begin
                        m_h[i] = (n > 63) ? 63 : n;
                        m_v[i] = (m_v[i] - 1 < -16) ? -16 : m_v[i] - 1;
                    end
                end
            end else begin
                if (edge_up == 1 && !crash) begin
                    m_mode[i] = M_GROUND; m_h[i] = 0; m_v[i] = 0; m_start[i] = 1;
                end
            end
        end
    endtask

    // Advance one clock, update the model, then compare both players just after the edge.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        jp_count0 += int'(jp_a[0]);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("pos%0d", i), 32'(pos_a[i]), 32'(m_h[i]));
            chk($sformatf("jumping%0d", i), 32'(jmp_a[i]), 32'(m_mode[i] == M_AIR));
            chk($sformatf("ducking%0d", i), 32'(duck_a[i]), 32'(m_duck[i]));
            chk($sformatf("start%0d", i), 32'(start_a[i]), 32'(m_start[i]));
            chk($sformatf("jpulse%0d", i), 32'(jp_a[i]), 32'(m_jp[i]));
            chk($sformatf("over%0d", i), 32'(over_a[i]), 32'(m_over[i]));
        end
    endtask

    task automatic tick_after(input int idle_clks);
        repeat (idle_clks) step();
        game_tick = 1'b1;
        step();
        game_tick = 1'b0;
    endtask

    int traj [15] = '{7, 13, 18, 22, 25, 27, 28, 28, 27, 25, 22, 18, 13, 7, 0};

    initial begin
        model_reset();
        #22;
        chk("reset_pos", 32'(pos_a[0]), 32'd0);
        chk("reset_start", 32'(start_a[0]), 32'd0);
        reset_n = 1'b1;

        // Button held through reset is not a start press.
        repeat (20) step();
        chk("idle_held_jumping", 32'(jmp_a[0]), 32'd0);
        button_up = 1'b0; step();
        button_up = 1'b1; step();
        chk("start_pulse_lit", 32'(start_a[0]), 32'd1);
        step();
        chk("start_pulse_once", 32'(start_a[0]), 32'd0);

        // Jump with re-presses mid-flight; player 1 clamps at the ceiling.
        button_up = 1'b0; step();
        jp_count0 = 0;
        button_up = 1'b1; game_tick = 1'b1; step(); game_tick = 1'b0;
        chk("launch_pos_lit", 32'(pos_a[0]), 32'd0);
        chk("launch_jumping_lit", 32'(jmp_a[0]), 32'd1);
        for (int t = 1; t <= 27; t++) begin
            if (t < 14) button_up = t[0];
            else button_up = 1'b0;
            tick_after(3);
            if (t <= 15) chk($sformatf("traj_t%0d", t), 32'(pos_a[0]), 32'(traj[t-1]));
            if (t == 5) chk("clamp_t5", 32'(pos_a[1]), 32'd63);
            if (t == 15) chk("land_jumping_lit", 32'(jmp_a[0]), 32'd0);
        end
        chk("jump_pulse_count", 32'(jp_count0), 32'd1);
        chk("p1_landed_lit", 32'(jmp_a[1]), 32'd0);

        // Duck, jump from duck, land while still holding down.
        button_down = 1'b1; step();
        chk("duck_lit", 32'(duck_a[0]), 32'd1);
        button_up = 1'b1; step();
        chk("duck_jump_ducking", 32'(duck_a[0]), 32'd0);
        chk("duck_jump_jumping", 32'(jmp_a[0]), 32'd1);
        button_up = 1'b0;
        for (int t = 1; t <= 27; t++) begin
            tick_after(1);
            if (t == 15) chk("land_in_duck", 32'(duck_a[0]), 32'd1);
        end
        button_down = 1'b0; step();

        // Crash mid-jump with a simultaneous tick, then restart.
        button_up = 1'b1; step();
        for (int t = 0; t < 4; t++) tick_after(1);
        chk("pre_crash_pos", 32'(pos_a[0]), 32'd22);
        crash = 1'b1; game_tick = 1'b1; step(); game_tick = 1'b0;
        chk("crash_pos", 32'(pos_a[0]), 32'd22);
        chk("crash_over", 32'(over_a[0]), 32'd1);
        button_up = 1'b0; step();
        chk("over_once", 32'(over_a[0]), 32'd0);
        button_up = 1'b1; step();
        chk("restart_blocked", 32'(start_a[0]), 32'd0);
        crash = 1'b0; button_up = 1'b0; step();
        button_up = 1'b1; step();
        chk("restart_start", 32'(start_a[0]), 32'd1);
        chk("restart_pos", 32'(pos_a[0]), 32'd0);

        // Asynchronous reset between edges in mid-air.
        button_up = 1'b0; step();
        button_up = 1'b1; step();
        for (int t = 0; t < 3; t++) tick_after(1);
        chk("pre_reset_pos", 32'(pos_a[0]), 32'd18);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_pos", 32'(pos_a[0]), 32'd0);
        chk("async_jumping", 32'(jmp_a[0]), 32'd0);
        chk("async_pos1", 32'(pos_a[1]), 32'd0);
        #3 reset_n = 1'b1;
        repeat (3) step();
        button_up = 1'b0; step();
        button_up = 1'b1; step();
        chk("post_reset_start", 32'(start_a[0]), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
